// File: rtl/fifo_pkg.sv
// Constants and types shared by the asynchronous FIFO blocks.
// f_bits gives the index/counter width needed to hold values 0..n-1.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PTR_WIDTH  = 4;

  typedef logic [DATA_WIDTH-1:0] rd_word_t;

  function automatic int f_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_stream_adapter_if.sv
// Valid/ready word stream from the FIFO read stage to its consumer.
interface rd_stream_adapter_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/rd_obuf.sv
// Small circular output buffer: push at tail, pop at head, occupancy 0..DEPTH.
// Contents are cleared on reset so the presented word reads 0 while empty.
module rd_obuf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [DATA_WIDTH-1:0]        i_push_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [f_bits(DEPTH+1)-1:0]   o_occ
);

  localparam int IDX_W = f_bits(DEPTH);
  localparam int OCC_W = f_bits(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_occ;

  // Explicit wrap so depths that are not a power of two stay in range.
  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= f_next(r_tail);
      end
      if (i_pop) r_head <= f_next(r_head);
      unique case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[r_head];
  assign o_occ   = r_occ;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_push |-> (r_occ != OCC_W'(DEPTH)));

endmodule

// File: rtl/rd_stream_adapter.sv
// FIFO read-side output stage: issues pops on credit, captures read data one
// cycle later into rd_obuf, and presents it as a valid/ready stream.
module rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_rclk,
  input  logic                  i_r_rst_n,
  input  logic                  i_empty,
  output logic                  o_r_en,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  rd_stream_adapter_if.master   m_stream,
  output logic [CNT_WIDTH-1:0]  o_rd_count
);

  localparam int OCC_W = f_bits(OBUF_DEPTH + 1);
  localparam int UW    = OCC_W + 1;

  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_rd_count;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_r_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic [OCC_W-1:0]      w_occ;
  logic [UW-1:0]         w_used;
  logic [UW-1:0]         w_limit;

  // occ + inflight - pop < DEPTH, rearranged to avoid unsigned underflow.
  assign w_pop   = w_valid & m_stream.m_ready;
  assign w_used  = UW'(w_occ) + UW'(r_inflight);
  assign w_limit = UW'(OBUF_DEPTH) + UW'(w_pop);
  assign w_r_en  = i_r_rst_n & ~i_empty & (w_used < w_limit);

  always_ff @(posedge i_rclk) begin
    if (!i_r_rst_n) begin
      r_inflight <= 1'b0;
      r_rd_count <= '0;
    end else begin
      r_inflight <= w_r_en;
      r_rd_count <= r_rd_count + CNT_WIDTH'(w_r_en);
    end
  end

  rd_obuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_DEPTH)
  ) u_obuf (
    .i_clk       (i_rclk),
    .i_rst_n     (i_r_rst_n),
    .i_push      (r_inflight),
    .i_push_data (i_rdata),
    .i_pop       (w_pop),
    .o_valid     (w_valid),
    .o_data      (w_data),
    .o_occ       (w_occ)
  );

  assign o_r_en          = w_r_en;
  assign o_rd_count      = r_rd_count;
  assign m_stream.m_valid = w_valid;
  assign m_stream.m_data  = w_data;

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Bench for rd_stream_adapter: depth-2 and depth-4 instances share stimulus and
// are checked every cycle against a word-index reference model.
`timescale 1ns/1ps
module tb_rd_stream_adapter;
  import fifo_pkg::*;

  localparam int CW = 16;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, empty, ready;
  rd_word_t      rdata2, rdata4;
  logic          r_en2, r_en4;
  logic [CW-1:0] cnt2, cnt4;

  rd_stream_adapter_if #(.DATA_WIDTH(DATA_WIDTH)) s2 ();
  rd_stream_adapter_if #(.DATA_WIDTH(DATA_WIDTH)) s4 ();
  assign s2.m_ready = ready;
  assign s4.m_ready = ready;

  rd_stream_adapter #(.DATA_WIDTH(DATA_WIDTH), .OBUF_DEPTH(2), .CNT_WIDTH(CW)) u_dut2 (
    .i_rclk(clk), .i_r_rst_n(rst_n), .i_empty(empty), .o_r_en(r_en2),
    .i_rdata(rdata2), .m_stream(s2), .o_rd_count(cnt2));

  rd_stream_adapter #(.DATA_WIDTH(DATA_WIDTH), .OBUF_DEPTH(4), .CNT_WIDTH(CW)) u_dut4 (
    .i_rclk(clk), .i_r_rst_n(rst_n), .i_empty(empty), .o_r_en(r_en4),
    .i_rdata(rdata4), .m_stream(s4), .o_rd_count(cnt4));

  // Reference: words are numbered by FIFO pop order; hd is the number of the
  // next word to deliver, occ the count held, inf a pop awaiting its data.
  int            src [NI];
  int            hd  [NI];
  int            occ [NI];
  bit            inf [NI];
  logic [CW-1:0] mcnt [NI];

  logic          s_valid [NI];
  rd_word_t      s_data  [NI];
  logic          s_ren   [NI];
  logic [CW-1:0] s_cnt   [NI];

  int n_chk, n_err;
  bit chk_en;

  typedef struct {
    logic          rst;
    logic          emp;
    logic          rdy;
    logic          ev;
    rd_word_t      ed;
    logic          er;
    logic [CW-1:0] ec;
  } vec_t;
  vec_t tbl [16];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic rd_word_t word_of(input int n);
    return rd_word_t'((n + 1) * 17);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst_i, input logic emp_i, input logic rdy_i);
    bit       mv [NI];
    bit       pp [NI];
    bit       er [NI];
    rd_word_t v;
    rst_n = rst_i;
    empty = emp_i;
    ready = rdy_i;
    @(negedge clk);
    s_valid[0] = s2.m_valid; s_data[0] = s2.m_data; s_ren[0] = r_en2; s_cnt[0] = cnt2;
    s_valid[1] = s4.m_valid; s_data[1] = s4.m_data; s_ren[1] = r_en4; s_cnt[1] = cnt4;
    for (int k = 0; k < NI; k++) begin
      mv[k] = (occ[k] != 0);
      pp[k] = mv[k] & rdy_i;
      er[k] = rst_i & ~emp_i & ((occ[k] + int'(inf[k]) - int'(pp[k])) < dep(k));
      if (chk_en) begin
        chk($sformatf("d%0d m_valid", dep(k)), 32'(s_valid[k]), 32'(mv[k]));
        if (mv[k]) chk($sformatf("d%0d m_data", dep(k)), 32'(s_data[k]), 32'(word_of(hd[k])));
        chk($sformatf("d%0d r_en", dep(k)), 32'(s_ren[k]), 32'(er[k]));
        chk($sformatf("d%0d rd_count", dep(k)), 32'(s_cnt[k]), 32'(mcnt[k]));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (!rst_i) begin
        occ[k] = 0; inf[k] = 1'b0; mcnt[k] = '0; hd[k] = src[k];
      end else begin
        if (pp[k]) hd[k]++;
        occ[k]  = occ[k] + int'(inf[k]) - int'(pp[k]);
        inf[k]  = er[k];
        mcnt[k] = mcnt[k] + CW'(er[k]);
      end
      if (er[k]) begin
        v = word_of(src[k]);
        src[k]++;
      end else begin
        v = rd_word_t'($urandom);
      end
      if (k == 0) rdata2 = v; else rdata4 = v;
    end
  endtask

  initial begin
    int base, bubbles;
    n_chk = 0; n_err = 0; chk_en = 1'b0;
    for (int k = 0; k < NI; k++) begin
      src[k] = 0; hd[k] = 0; occ[k] = 0; inf[k] = 1'b0; mcnt[k] = '0;
    end
    rdata2 = '0; rdata4 = '0; rst_n = 1'b0; empty = 1'b1; ready = 1'b0;

    // empty falls at row 10 for three pops; data 0x11, 0x22, 0x33
    for (int i = 0; i < 16; i++) begin
      tbl[i].rst = 1'b1; tbl[i].rdy = 1'b1;
      tbl[i].emp = (i >= 10 && i <= 12) ? 1'b0 : 1'b1;
      tbl[i].ev = 1'b0; tbl[i].ed = '0; tbl[i].er = 1'b0; tbl[i].ec = '0;
    end
    tbl[10].er = 1'b1;
    tbl[11].er = 1'b1; tbl[11].ec = 16'd1;
    tbl[12].er = 1'b1; tbl[12].ec = 16'd2; tbl[12].ev = 1'b1; tbl[12].ed = 8'h11;
    tbl[13].ec = 16'd3; tbl[13].ev = 1'b1; tbl[13].ed = 8'h22;
    tbl[14].ec = 16'd3; tbl[14].ev = 1'b1; tbl[14].ed = 8'h33;
    tbl[15].ec = 16'd3;

    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].emp, tbl[i].rdy);
      if (i == 0) begin
        chk("reset d2 m_data", 32'(s_data[0]), 32'h0);
        chk("reset d4 m_data", 32'(s_data[1]), 32'h0);
      end
      chk($sformatf("tbl[%0d] m_valid", i), 32'(s_valid[0]), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl[%0d] m_data", i), 32'(s_data[0]), 32'(tbl[i].ed));
      chk($sformatf("tbl[%0d] r_en", i), 32'(s_ren[0]), 32'(tbl[i].er));
      chk($sformatf("tbl[%0d] rd_count", i), 32'(s_cnt[0]), 32'(tbl[i].ec));
    end

    // backpressure from the first cycle, then resume
    step(1'b0, 1'b1, 1'b1);
    base = src[0];
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("bp d2 rd_count", 32'(s_cnt[0]), 32'd2);
    chk("bp d2 r_en", 32'(s_ren[0]), 32'd0);
    chk("bp d2 m_data", 32'(s_data[0]), 32'(word_of(base)));
    chk("bp d4 rd_count", 32'(s_cnt[1]), 32'd4);
    chk("bp d4 r_en", 32'(s_ren[1]), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("resume d2 r_en", 32'(s_ren[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("resume d2 m_valid", 32'(s_valid[0]), 32'd1);
      chk("resume d2 m_data", 32'(s_data[0]), 32'(word_of(base + i)));
      step(1'b1, 1'b0, 1'b1);
    end

    // reset while d4 holds two words with a third in flight
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst d4 m_valid", 32'(s_valid[1]), 32'd1);
    chk("midrst d4 rd_count", 32'(s_cnt[1]), 32'd3);
    chk("midrst d4 r_en", 32'(s_ren[1]), 32'd0);
    chk("midrst d2 r_en", 32'(s_ren[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("postrst d4 m_valid", 32'(s_valid[1]), 32'd0);
      chk("postrst d2 m_valid", 32'(s_valid[0]), 32'd0);
      chk("postrst d4 rd_count", 32'(s_cnt[1]), 32'd0);
    end

    // toggling empty, then random empty/ready, then drain
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) step(1'b1, 1'(i % 2), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++)
      step(1'b1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    chk("drain d2 m_valid", 32'(s_valid[0]), 32'd0);
    chk("drain d4 m_valid", 32'(s_valid[1]), 32'd0);

    // rd_count wrap
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("wrap d2 ffff", 32'(s_cnt[0]), 32'hFFFF);
    chk("wrap d4 ffff", 32'(s_cnt[1]), 32'hFFFF);
    step(1'b1, 1'b0, 1'b1);
    chk("wrap d2 0000", 32'(s_cnt[0]), 32'h0);
    chk("wrap d4 0000", 32'(s_cnt[1]), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    chk("wrap d2 0001", 32'(s_cnt[0]), 32'h1);

    // continuous flow on the depth-4 instance
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("flow fill0 m_valid", 32'(s_valid[1]), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("flow fill1 m_valid", 32'(s_valid[1]), 32'd0);
    bubbles = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (!(s_valid[1] === 1'b1 && s_ren[1] === 1'b1)) bubbles++;
    end
    chk("flow d4 bubbles", 32'(bubbles), 32'd0);
    chk("flow d4 rd_count", 32'(s_cnt[1]), 32'd1001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rd_stream_adapter.md
# rd_stream_adapter

Read-domain output stage of the asynchronous FIFO, directly downstream of the read pointer block. It watches `empty` and generates the `r_en` pop requests. It captures memory read data, which arrives one cycle after each pop, into a small output buffer. It presents the buffered words on a valid/ready stream to the consuming logic, so that backpressure never loses a word and a steady stream runs at one word per cycle.

## Interface
- `DATA_WIDTH`, 8: width of FIFO memory words and of the stream data.
- `OBUF_DEPTH`, 2: output buffer entries. Legal range is 2..8. 2 is the minimum for full throughput.
- `CNT_WIDTH`, 16: width of the popped-word counter.

Ports:
- `rclk`  in  1  read-domain clock.
- `r_rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `empty`  in  1  FIFO empty flag from the read pointer block.
- `r_en`  out  1  pop request to the read pointer block and to the memory read enable.
- `rdata`  in  DATA_WIDTH  memory read data. Valid in the cycle after a cycle with `r_en`=1.
- `m_valid`  out  1  stream word available.
- `m_data`  out  DATA_WIDTH  stream word. Stable while `m_valid`=1 and `m_ready`=0.
- `m_ready`  in  1  consumer accepts the word.
- `rd_count`  out  CNT_WIDTH  total words popped since reset. Wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - `occ`: buffer occupancy, 0..OBUF_DEPTH.
  - `inflight`: 1 bit, set when a pop was issued in the previous cycle.
  - Circular buffer addressed by head and tail indices.
- `pop` = `m_valid` & `m_ready`.
- `r_en` = `r_rst_n` & !`empty` & (`occ` + `inflight` − `pop` < OBUF_DEPTH).
  - Combinational from registered state and inputs.
  - Never asserted while `empty`=1 or while reset is low.
- Capture: if `inflight`=1, `rdata` is written at the tail and the tail advances modulo OBUF_DEPTH.
- `occ` next = `occ` + `inflight` − `pop`. A capture and a pop in the same cycle leave `occ` unchanged.
- `m_valid` = (`occ` != 0). `m_data` = buffer[head]. The head advances on `pop`.
- `rd_count` increments on every cycle with `r_en`=1 and wraps from all-ones to 0.
- The credit rule keeps `occ` + `inflight` ≤ OBUF_DEPTH. Buffer overflow is unreachable. A capture with `occ`=OBUF_DEPTH is an assertion failure.
- No FSM beyond these counters. Ordering is strict FIFO, with no reordering or dropping.

## Timing
- Reset: a `rclk` edge with `r_rst_n`=0 gives:
  - `occ`=0, `inflight`=0, head=tail=0, `rd_count`=0.
  - Outputs: `m_valid`=0 and `r_en`=0. `m_data` is don't-care (the implementation clears it to 0).
- Reset mid-operation: buffered and in-flight words are discarded. The first cycle after release behaves as after power-up.
- Latency: `r_en` in cycle N, capture at the end of N+1, `m_valid`=1 in N+2.
  - `empty` falling in cycle E gives first `m_valid` in E+2.
- Throughput: with `m_ready` held at 1 and `empty`=0, `r_en`=1 and `m_valid`=1 every cycle from E+2 on.
- Backpressure with `m_ready`=0: issue stops once `occ` + `inflight` = OBUF_DEPTH. The word in flight is still captured.
  - When `m_ready` returns to 1, `r_en` re-asserts in that same cycle.
- `empty` rising while a word is in flight: the word is still captured and delivered.
- `m_data` is never `rdata` passed through combinationally. There is always at least a 1-cycle register stage.

## Structure
- Shared package `fifo_pkg` holds:
  - the DATA_WIDTH and PTR_WIDTH constants used by the whole FIFO;
  - a `rd_word_t` typedef (logic [DATA_WIDTH-1:0]).
- Natural sub-module: `rd_obuf`, the OBUF_DEPTH circular buffer with push/pop/occupancy. The top level holds the credit logic, `inflight` and `rd_count`.

## Test plan
- Reset, then `empty` falls at cycle 10 with `rdata` sequence 0x11, 0x22, 0x33, `m_ready`=1 → `r_en` high from cycle 10, `m_valid` at 12, words delivered 0x11, 0x22, 0x33 in consecutive cycles.
- `empty`=0 continuously, `m_ready`=0 from cycle 5 → exactly 2 pops issued (OBUF_DEPTH=2), `r_en`=0 after, `m_data` held at the first word. `m_ready`=1 then resumes with no loss or duplication.
- `empty` toggles 1/0 every cycle, `m_ready` random → output order equals pop order, and `rd_count` equals the number of `r_en` cycles.
- `r_rst_n` low for 1 cycle with `occ`=2 and `inflight`=1 → next cycle `m_valid`=0, `rd_count`=0, and the in-flight word is not delivered.
- `rd_count` preloaded near wrap by running 65535 pops, then 2 more → reads 0xFFFF, then 0x0000, then 0x0001.
- Continuous flow for 1000 words, OBUF_DEPTH=4 → 1 word per cycle after the 2-cycle fill, no bubbles.
